slice_sequencer: RTL
====================

# slice_sequencer

Control FSM for the 64-slice, 1600-bit state datapath. One `start` launches one or more passes. Each pass clears the slice registers, then walks `cntSelOut` 0→63 with `regWrite` asserted so that one 25-bit slice is transformed and stored per cycle. Between passes it selects datapath feedback (`out`→`in`) for multi-round operation, and it reports completion with a `done` pulse.

## Interface
Parameters:
- `ROUNDS`, 1: passes per `start`; legal range 1..255.

Ports:
- `clk` input, 1 bit: sole clock, rising edge.
- `rst` input, 1 bit: reset, synchronous, active-high.
- `start` input, 1 bit: launch request; sampled only in IDLE.
- `hold` input, 1 bit: stall; freezes slice and round counters and deasserts `regWrite` while high in RUN.
- `cntSelOut` output, 6 bits: slice select to the datapath mux and decoder.
- `regRst` output, 1 bit: slice-register clear, high for exactly one cycle per launch.
- `regWrite` output, 1 bit: slice write enable.
- `inSel` output, 1 bit: input source select; 0 = external state, 1 = datapath feedback.
- `ready` output, 1 bit: high in IDLE only.
- `done` output, 1 bit: one-cycle completion pulse.

## Operation
- States are IDLE, CLEAR, RUN, NEXT, DONE. Outputs are decoded from the state and counters (Moore).
- **IDLE:** `ready=1`; all other outputs 0. If `start=1`, go to CLEAR; otherwise stay.
- **CLEAR:** `regRst=1`, slice counter = 0, round counter = 0. Go to RUN next cycle unconditionally; `hold` is ignored here.
- **RUN:**
  - `cntSelOut` = slice counter; `regWrite = ~hold`.
  - `inSel` = 0 in round 0, 1 in later rounds.
  - With `hold=0`, the slice counter increments each cycle.
  - At slice 63 with `hold=0`: if round counter = ROUNDS−1, go to DONE; otherwise go to NEXT.
  - With `hold=1`, state and counters are frozen.
- **NEXT:** `regWrite=0`, `inSel=1`. Increment the round counter, reset the slice counter to 0, then go to RUN. No `regRst`; the state carries over.
- **DONE:** `done=1` for one cycle, then go to IDLE. `start` is not sampled in DONE.
- `start` outside IDLE is ignored and is not queued.
- The slice counter is 6 bits and never wraps inside RUN; the 63 exit is decoded explicitly.
- The round counter is 8 bits.
- **Reset:** `rst=1` at any edge, including mid-RUN, forces IDLE with both counters at 0.
  - After reset: `ready=1`, `cntSelOut=0`, `regRst=0`, `regWrite=0`, `inSel=0`, `done=0`.
  - A partial datapath state is abandoned; the next launch clears it via CLEAR.
- `rst` and `start` in the same cycle: reset wins.

## Timing
- Let cycle 0 be the cycle in which `start` is sampled high in IDLE.
- CLEAR occupies cycle 1.
- With no `hold`:
  - Round r RUN occupies cycles 2+65r .. 65+65r, with `cntSelOut` = cycle−2−65r.
  - NEXT occupies cycle 66+65r.
- `done` is high in cycle 65·ROUNDS+1 (66 for ROUNDS=1, 131 for ROUNDS=2). `ready` returns the following cycle.
- Each `hold` cycle in RUN delays all later events by one cycle.
- The earliest relaunch is: `start` sampled in the first IDLE cycle after DONE.

## Structure
- **Package `slice_seq_pkg`:**
  - State encoding constants.
  - `SLICES=64`, `SEL_W=6`, `RND_W=8`.
- **Sub-module `slice_counter6`:**
  - Inputs: `clk`, `rst`, `clr`, `en`.
  - Outputs: 6-bit `count` and a `last` flag (count==63).
  - Used as the slice counter; the round counter stays inline in the FSM.

## Test plan
- **Reset:** assert `rst` 2 cycles → `ready=1`, every other output 0, state IDLE.
- **Single round (ROUNDS=1):** `start` pulse in cycle 0 →
  - `regRst` in cycle 1 only.
  - `regWrite=1` and `cntSelOut` 0..63 in cycles 2..65, `inSel=0` throughout.
  - `done` in cycle 66; `ready=1` in cycle 67.
- **Multi-round (ROUNDS=2):**
  - NEXT in cycle 66: `regWrite=0`, `inSel=1`.
  - Second sweep in cycles 67..130 with `inSel=1`.
  - `done` in cycle 131; `regRst` asserted only once.
- **Hold:** `hold=1` for 3 cycles while `cntSelOut=10` → `cntSelOut` stays at 10 with `regWrite=0`, then resumes at 11; `done` arrives 3 cycles later (cycle 69).
- **Start while busy:** pulse `start` at cycle 30 → no effect; `done` still in cycle 66 and exactly one `regRst`.
- **Reset mid-run:** `rst` at cycle 40 → IDLE with reset outputs next cycle, no `done`. A new `start` then gives the full nominal sequence.

Source files
------------

// File: rtl/slice_seq_pkg.sv
// Shared definitions for the slice sequencer slice.
//   state_e : FSM state encoding (IDLE, CLEAR, RUN, NEXT, DONE)
//   SLICES  : slices per pass; SEL_W : slice select width; RND_W : round counter width
package slice_seq_pkg;
  localparam int SLICES = 64;
  localparam int SEL_W  = 6;
  localparam int RND_W  = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_RUN   = 3'd2,
    ST_NEXT  = 3'd3,
    ST_DONE  = 3'd4
  } state_e;
endpackage

// File: rtl/slice_counter6.sv
// 6-bit slice counter with synchronous clear and count enable.
//   clk, rst : clock, synchronous active-high reset
//   clr      : force count to 0 (wins over en)
//   en       : increment by one
//   count    : current slice index
//   last     : count == SLICES-1
module slice_counter6
  import slice_seq_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [SEL_W-1:0] count,
  output logic             last
);
  logic [SEL_W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (rst || clr)  count_q <= '0;
    else if (en)     count_q <= count_q + 1'b1;
  end

  assign count = count_q;
  assign last  = (count_q == SEL_W'(SLICES - 1));
endmodule

// File: rtl/slice_sequencer.sv
// Control FSM for the 64-slice state datapath. One start runs ROUNDS passes,
// each sweeping cntSelOut 0..63 with regWrite, then pulses done.
//   clk, rst  : clock, synchronous active-high reset
//   start     : launch request, only honoured in IDLE
//   hold      : stalls the sweep while in RUN
//   cntSelOut : slice select to datapath mux/decoder
//   regRst    : one-cycle slice-register clear per launch
//   regWrite  : slice write enable
//   inSel     : 0 = external state, 1 = datapath feedback
//   ready     : high in IDLE
//   done      : one-cycle completion pulse
module slice_sequencer
  import slice_seq_pkg::*;
#(
  parameter int ROUNDS = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             hold,
  output logic [SEL_W-1:0] cntSelOut,
  output logic             regRst,
  output logic             regWrite,
  output logic             inSel,
  output logic             ready,
  output logic             done
);
  localparam logic [RND_W-1:0] LAST_RND = RND_W'(ROUNDS - 1);

  state_e           state_q;
  logic [RND_W-1:0] rnd_q;
  logic [SEL_W-1:0] slice;
  logic             slice_last;
  logic             in_run, step, sweep_end;

  assign in_run    = (state_q == ST_RUN);
  assign step      = in_run && !hold;
  assign sweep_end = step && slice_last;

  // The counter is parked at 0 outside RUN so every sweep starts from slice 0.
  slice_counter6 u_slice (
    .clk   (clk),
    .rst   (rst),
    .clr   ((state_q == ST_CLEAR) || (state_q == ST_NEXT) || sweep_end),
    .en    (step),
    .count (slice),
    .last  (slice_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      rnd_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE:  if (start) state_q <= ST_CLEAR;
        ST_CLEAR: begin
          rnd_q   <= '0;
          state_q <= ST_RUN;
        end
        ST_RUN:   if (sweep_end) state_q <= (rnd_q == LAST_RND) ? ST_DONE : ST_NEXT;
        ST_NEXT: begin
          rnd_q   <= rnd_q + 1'b1;
          state_q <= ST_RUN;
        end
        ST_DONE:  state_q <= ST_IDLE;
        default:  state_q <= ST_IDLE;
      endcase
    end
  end

  // Moore decode; regWrite additionally gated by hold so stalled cycles write nothing.
  always_comb begin
    cntSelOut = '0;
    regRst    = 1'b0;
    regWrite  = 1'b0;
    inSel     = 1'b0;
    ready     = 1'b0;
    done      = 1'b0;
    case (state_q)
      ST_IDLE:  ready = 1'b1;
      ST_CLEAR: regRst = 1'b1;
      ST_RUN: begin
        cntSelOut = slice;
        regWrite  = !hold;
        inSel     = (rnd_q != '0);
      end
      ST_NEXT:  inSel = 1'b1;
      ST_DONE:  done = 1'b1;
      default:  ;
    endcase
  end
endmodule
